// File: rtl/image_rom_arbiter.sv
// Shares the single-read-port image ROM between VGA scanout and a host read port.
// Scanout always wins; the host gets every cycle scanout does not need. Each
// requester sees a fixed 3-clock latency. Host starvation is tracked and flagged.
module image_rom_arbiter #(
    parameter int unsigned IMG_W        = 640,
    parameter int unsigned IMG_H        = 480,
    parameter int unsigned CW           = 10,
    parameter logic [3:0]  BG_COLOR     = 4'h0,
    parameter int unsigned STARVE_LIMIT = 1024,
    localparam int unsigned AW          = $clog2(IMG_W * IMG_H)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          scan_en,
    input  logic [CW-1:0] scan_x,
    input  logic [CW-1:0] scan_y,
    output logic          scan_valid,
    output logic [3:0]    scan_pixel,
    input  logic          host_valid,
    input  logic [AW-1:0] host_addr,
    output logic          host_ready,
    output logic          host_rsp_valid,
    output logic [3:0]    host_rsp_data,
    output logic [AW-1:0] rom_addr,
    input  logic [3:0]    rom_pixel,
    output logic          host_starved,
    input  logic          starve_clr
);

    localparam int unsigned IMG_SIZE = IMG_W * IMG_H;
    localparam int unsigned SW       = $clog2(STARVE_LIMIT + 1);

    // Per-slot request tag. Both requesters can occupy one slot when the scan
    // request is out of image (no ROM access), so each keeps its own bg bit.
    typedef struct packed {
        logic scan;
        logic scan_bg;
        logic host;
        logic host_bg;
    } tag_t;

    logic          scan_hit;
    logic          host_in_img;
    logic          host_grant;
    logic [31:0]   scan_lin;

    logic [AW-1:0] rom_addr_d, rom_addr_q;
    tag_t          tag0_d, tag0_q, tag1_q;

    logic          scan_valid_d, scan_valid_q;
    logic [3:0]    scan_pixel_d, scan_pixel_q;
    logic          host_rsp_valid_d, host_rsp_valid_q;
    logic [3:0]    host_rsp_data_d, host_rsp_data_q;

    logic [SW-1:0] starve_cnt_d, starve_cnt_q;
    logic          starved_d, starved_q;

    // Arbitration: an in-image scan pixel owns the ROM, anything else frees it for the host
    always_comb begin
        scan_hit    = scan_en && (32'(scan_x) < IMG_W) && (32'(scan_y) < IMG_H);
        host_ready  = ~scan_hit;
        host_grant  = host_valid & ~scan_hit;
        host_in_img = 32'(host_addr) < IMG_SIZE;
        scan_lin    = 32'(scan_y) * IMG_W + 32'(scan_x);
    end

    // ROM address and stage-0 tag for the request presented this cycle
    always_comb begin
        rom_addr_d = rom_addr_q;
        if (scan_hit) begin
            rom_addr_d = scan_lin[AW-1:0];
        end else if (host_grant && host_in_img) begin
            rom_addr_d = host_addr;
        end
        tag0_d.scan    = scan_en;
        tag0_d.scan_bg = scan_en & ~scan_hit;
        tag0_d.host    = host_grant;
        tag0_d.host_bg = host_grant & ~host_in_img;
    end

    // Output stage: pair ROM data with the stage-1 tag; pixels hold while idle
    always_comb begin
        scan_valid_d     = tag1_q.scan;
        scan_pixel_d     = scan_pixel_q;
        host_rsp_valid_d = tag1_q.host;
        host_rsp_data_d  = host_rsp_data_q;
        if (tag1_q.scan) begin
            scan_pixel_d = tag1_q.scan_bg ? BG_COLOR : rom_pixel;
        end
        if (tag1_q.host) begin
            host_rsp_data_d = tag1_q.host_bg ? BG_COLOR : rom_pixel;
        end
    end

    // Starvation counter saturates at the limit; clear wins over a same-cycle set
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (starve_clr || !host_valid || host_ready) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q != SW'(STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end
        if (starve_clr) begin
            starved_d = 1'b0;
        end else begin
            starved_d = starved_q | (starve_cnt_d == SW'(STARVE_LIMIT));
        end
    end

    // State registers; reset discards anything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_q       <= '0;
            tag0_q           <= '0;
            tag1_q           <= '0;
            scan_valid_q     <= 1'b0;
            scan_pixel_q     <= '0;
            host_rsp_valid_q <= 1'b0;
            host_rsp_data_q  <= '0;
            starve_cnt_q     <= '0;
            starved_q        <= 1'b0;
        end else begin
            rom_addr_q       <= rom_addr_d;
            tag0_q           <= tag0_d;
            tag1_q           <= tag0_q;
            scan_valid_q     <= scan_valid_d;
            scan_pixel_q     <= scan_pixel_d;
            host_rsp_valid_q <= host_rsp_valid_d;
            host_rsp_data_q  <= host_rsp_data_d;
            starve_cnt_q     <= starve_cnt_d;
            starved_q        <= starved_d;
        end
    end

    assign rom_addr       = rom_addr_q;
    assign scan_valid     = scan_valid_q;
    assign scan_pixel     = scan_pixel_q;
    assign host_rsp_valid = host_rsp_valid_q;
    assign host_rsp_data  = host_rsp_data_q;
    assign host_starved   = starved_q;

endmodule

// File: tb/tb_image_rom_arbiter.sv
// Bench for image_rom_arbiter: directed scenarios plus random traffic checked
// against a transaction-level model (queue of expected responses, 3-clk latency).
module tb_image_rom_arbiter;

    localparam int unsigned IMG_W = 640;
    localparam int unsigned IMG_H = 480;
    localparam int unsigned CW    = 10;
    localparam int unsigned AW    = 19;
    localparam int unsigned LIM   = 8;
    localparam logic [3:0]  BG    = 4'h0;

    typedef struct packed {
        logic       sv;
        logic [3:0] sp;
        logic       hv;
        logic [3:0] hd;
    } rsp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          scan_en = 1'b0;
    logic [CW-1:0] scan_x = '0;
    logic [CW-1:0] scan_y = '0;
    logic          scan_valid;
    logic [3:0]    scan_pixel;
    logic          host_valid = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic          host_ready;
    logic          host_rsp_valid;
    logic [3:0]    host_rsp_data;
    logic [AW-1:0] rom_addr;
    logic [3:0]    rom_pixel = 4'h0;
    logic          host_starved;
    logic          starve_clr = 1'b0;

    int   checks = 0;
    int   errors = 0;

    // Model state
    rsp_t       q[$];
    logic [3:0] last_sp = 4'h0;
    logic [3:0] last_hd = 4'h0;
    int         scnt = 0;
    logic       exp_st = 1'b0;
    logic [9:0] exp_out = '0;
    logic       exp_rdy = 1'b1;
    logic       obs_rdy;

    always #5 clk = ~clk;

    // ROM with 1-cycle registered read, content = low nibble of address
    always @(posedge clk) rom_pixel <= rom_addr[3:0];

    image_rom_arbiter #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .CW(CW), .BG_COLOR(BG), .STARVE_LIMIT(LIM)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .scan_en(scan_en), .scan_x(scan_x), .scan_y(scan_y),
        .scan_valid(scan_valid), .scan_pixel(scan_pixel),
        .host_valid(host_valid), .host_addr(host_addr), .host_ready(host_ready),
        .host_rsp_valid(host_rsp_valid), .host_rsp_data(host_rsp_data),
        .rom_addr(rom_addr), .rom_pixel(rom_pixel),
        .host_starved(host_starved), .starve_clr(starve_clr)
    );

    // One clock of stimulus; updates the model's expectations for after the edge.
    task automatic step(input logic sen, input logic [CW-1:0] sx, input logic [CW-1:0] sy,
                        input logic hv, input logic [AW-1:0] ha, input logic clr);
        rsp_t r;
        bit   in_img, grant;
        scan_en = sen; scan_x = sx; scan_y = sy;
        host_valid = hv; host_addr = ha; starve_clr = clr;
        #1;
        obs_rdy = host_ready;
        in_img  = sen && (int'(sx) < IMG_W) && (int'(sy) < IMG_H);
        exp_rdy = !in_img;
        grant   = hv && !in_img;
        r.sv = sen;
        r.sp = in_img ? 4'((int'(sy) * IMG_W + int'(sx)) % 16) : BG;
        r.hv = grant;
        r.hd = (int'(ha) < IMG_W * IMG_H) ? 4'(int'(ha) % 16) : BG;
        q.push_back(r);
        if (clr) begin
            scnt = 0; exp_st = 1'b0;
        end else begin
            if (!hv || grant) scnt = 0;
            else if (scnt < LIM) scnt++;
            if (scnt == LIM) exp_st = 1'b1;
        end
        @(posedge clk); #1;
        if (q.size() == 3) begin
            r = q.pop_front();
            if (r.sv) last_sp = r.sp;
            if (r.hv) last_hd = r.hd;
            exp_out = {r.sv, last_sp, r.hv, last_hd};
        end else begin
            exp_out = {1'b0, last_sp, 1'b0, last_hd};
        end
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    // Assert reset between edges and forget everything in flight
    task automatic hold_reset();
        rst_n = 1'b0;
        #2;
        q.delete();
        last_sp = 4'h0; last_hd = 4'h0; scnt = 0; exp_st = 1'b0;
    endtask

    task automatic test_reset();
        hold_reset();
        if ({scan_valid, scan_pixel, host_rsp_valid, host_rsp_data, rom_addr, host_starved}
            !== '0 || host_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in: outs=%h %h %h %h addr=%0d st=%b rdy=%b want all 0 rdy=1",
                     scan_valid, scan_pixel, host_rsp_valid, host_rsp_data, rom_addr,
                     host_starved, host_ready);
        end
        checks++;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            idle();
            if (obs_rdy !== 1'b1 || {scan_valid, scan_pixel, host_rsp_valid, host_rsp_data,
                rom_addr, host_starved} !== '0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: rdy=%b sv=%b sp=%h hv=%b hd=%h addr=%0d st=%b want 0s rdy=1",
                         i, obs_rdy, scan_valid, scan_pixel, host_rsp_valid, host_rsp_data,
                         rom_addr, host_starved);
            end
            checks++;
        end
    endtask

    task automatic test_scan_pixel();
        step(1'b1, 10'd5, 10'd2, 1'b0, '0, 1'b0);
        if (rom_addr !== 19'd1285) begin
            errors++; $display("FAIL scan_addr: got %0d want 1285", rom_addr);
        end
        checks++;
        idle();
        idle();
        if (scan_valid !== 1'b1 || scan_pixel !== 4'h5 || host_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL scan_pixel: sv=%b sp=%h hv=%b want sv=1 sp=5 hv=0",
                     scan_valid, scan_pixel, host_rsp_valid);
        end
        checks++;
        idle();
        if (scan_valid !== 1'b0 || scan_pixel !== 4'h5) begin
            errors++; $display("FAIL scan_hold: sv=%b sp=%h want sv=0 sp=5", scan_valid, scan_pixel);
        end
        checks++;
    endtask

    task automatic test_host_blocked_line();
        for (int x = 0; x < 640; x++) begin
            step(1'b1, CW'(x), 10'd0, 1'b1, 19'd7, 1'b0);
            if (obs_rdy !== 1'b0 || {scan_valid, scan_pixel, host_rsp_valid, host_rsp_data}
                !== exp_out) begin
                errors++;
                $display("FAIL line[%0d]: rdy=%b outs=%h want rdy=0 outs=%h", x, obs_rdy,
                         {scan_valid, scan_pixel, host_rsp_valid, host_rsp_data}, exp_out);
            end
            checks++;
        end
        step(1'b0, '0, '0, 1'b1, 19'd7, 1'b0);
        if (obs_rdy !== 1'b1) begin
            errors++; $display("FAIL blank_grant: rdy=%b want 1", obs_rdy);
        end
        checks++;
        idle();
        idle();
        if (host_rsp_valid !== 1'b1 || host_rsp_data !== 4'h7) begin
            errors++;
            $display("FAIL host_after_line: hv=%b hd=%h want hv=1 hd=7", host_rsp_valid, host_rsp_data);
        end
        checks++;
    endtask

    task automatic test_bg_concurrent();
        step(1'b1, 10'd700, 10'd3, 1'b1, 19'd307199, 1'b0);
        if (obs_rdy !== 1'b1) begin
            errors++; $display("FAIL bg_ready: rdy=%b want 1", obs_rdy);
        end
        checks++;
        idle();
        idle();
        if ({scan_valid, scan_pixel, host_rsp_valid, host_rsp_data} !== {1'b1, BG, 1'b1, 4'hF})
        begin
            errors++;
            $display("FAIL bg_concurrent: sv=%b sp=%h hv=%b hd=%h want 1 %h 1 f",
                     scan_valid, scan_pixel, host_rsp_valid, host_rsp_data, BG);
        end
        checks++;
        // Out-of-range host address with no scan: background colour, same latency
        step(1'b0, '0, '0, 1'b1, 19'd400000, 1'b0);
        idle();
        idle();
        if (host_rsp_valid !== 1'b1 || host_rsp_data !== BG) begin
            errors++;
            $display("FAIL host_oob: hv=%b hd=%h want 1 %h", host_rsp_valid, host_rsp_data, BG);
        end
        checks++;
    endtask

    task automatic test_starvation();
        step(1'b0, '0, '0, 1'b0, '0, 1'b1);
        for (int round = 0; round < 2; round++) begin
            for (int i = 1; i <= 8; i++) begin
                step(1'b1, CW'(i), 10'd1, 1'b1, 19'd100, 1'b0);
                if (host_starved !== (i == 8)) begin
                    errors++;
                    $display("FAIL starve[%0d.%0d]: got %b want %b", round, i, host_starved, i == 8);
                end
                checks++;
            end
            if (round == 0) begin
                step(1'b1, 10'd20, 10'd1, 1'b1, 19'd100, 1'b1);
                if (host_starved !== 1'b0) begin
                    errors++; $display("FAIL starve_clr: got %b want 0", host_starved);
                end
                checks++;
            end
        end
        step(1'b0, '0, '0, 1'b1, 19'd100, 1'b0);
        if (host_starved !== 1'b1) begin
            errors++; $display("FAIL starve_sticky: got %b want 1", host_starved);
        end
        checks++;
        idle();
        idle();
        idle();
    endtask

    task automatic test_reset_inflight();
        step(1'b1, 10'd10, 10'd10, 1'b0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b1, 19'd50, 1'b0);
        hold_reset();
        if ({scan_valid, host_rsp_valid, host_starved, rom_addr} !== '0) begin
            errors++;
            $display("FAIL rst_inflight: sv=%b hv=%b st=%b addr=%0d want 0s",
                     scan_valid, host_rsp_valid, host_starved, rom_addr);
        end
        checks++;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idle();
            if (scan_valid !== 1'b0 || host_rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL ghost_rsp[%0d]: sv=%b hv=%b want 0 0", i, scan_valid, host_rsp_valid);
            end
            checks++;
        end
        step(1'b0, '0, '0, 1'b1, 19'd42, 1'b0);
        idle();
        if (host_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL post_rst_early: hv=%b want 0", host_rsp_valid);
        end
        checks++;
        idle();
        if (host_rsp_valid !== 1'b1 || host_rsp_data !== 4'hA) begin
            errors++;
            $display("FAIL post_rst_rsp: hv=%b hd=%h want 1 a", host_rsp_valid, host_rsp_data);
        end
        checks++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0), CW'($urandom_range(0, 799)),
                 CW'($urandom_range(0, 524)), 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 307199 + 40)), 1'($urandom_range(0, 31) == 0));
            if (obs_rdy !== exp_rdy || host_starved !== exp_st ||
                {scan_valid, scan_pixel, host_rsp_valid, host_rsp_data} !== exp_out) begin
                errors++;
                $display("FAIL random[%0d]: rdy=%b st=%b outs=%h want rdy=%b st=%b outs=%h", i,
                         obs_rdy, host_starved, {scan_valid, scan_pixel, host_rsp_valid,
                         host_rsp_data}, exp_rdy, exp_st, exp_out);
            end
            checks++;
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_scan_pixel();
        test_host_blocked_line();
        test_bg_concurrent();
        test_starvation();
        test_reset_inflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
